axi_burst_read_master: RTL and testbench
========================================

# axi_burst_read_master

Parametrised AXI4 read master that turns one client request into one INCR burst of runtime-selectable length (1..MAX_BEATS beats) and returns the assembled line as a single wide response. It sits between a cache/fetch unit and the AXI read channel. It generalises the fixed-length read master with the following additions:

- a request-ready handshake;
- per-request burst length;
- beat-width parameterisation;
- RRESP/RLAST error reporting;
- a received-beat count.

## Interface
Parameters:
- DATA_WIDTH, 32, AXI beat width in bits; power of two, 8..1024.
- MAX_BEATS, 8, beats per response buffer; power of two, 1..256.
- ADDR_WIDTH, 32, AXI address width.

Derived values:
- LEN_W = max(1, clog2(MAX_BEATS)).
- CNT_W = clog2(MAX_BEATS+1).
- SIZE = clog2(DATA_WIDTH/8).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous, active-low.
- req_valid  input  1  client request strobe.
- req_ready  output  1  block can accept a request.
- req_addr  input  ADDR_WIDTH  burst start address.
- req_len  input  LEN_W  beats minus one.
- resp_valid  output  1  one-cycle completion pulse.
- resp_data  output  MAX_BEATS*DATA_WIDTH  assembled data; beat i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- resp_err  output  1  burst had an error; valid with resp_valid.
- resp_beats  output  CNT_W  beats stored; valid with resp_valid.
- arvalid  output  1  AXI AR valid.
- arready  input  1  AXI AR ready.
- araddr  output  ADDR_WIDTH  AXI AR address.
- arlen  output  8  AXI AR length; req_len zero-extended.
- arsize  output  3  AXI AR size; constant SIZE.
- arburst  output  2  AXI AR burst type; constant 2'b01 (INCR).
- rvalid  input  1  AXI R valid.
- rready  output  1  AXI R ready.
- rdata  input  DATA_WIDTH  AXI R data.
- rresp  input  2  AXI R response.
- rlast  input  1  AXI R last beat.

## Operation
- States and transitions:
  - IDLE → AR on req_valid && req_ready.
  - AR → R on arready.
  - R → RESP on an rvalid && rlast beat.
  - RESP → IDLE unconditionally.
- Output decodes: req_ready = (state==IDLE); arvalid = (state==AR); rready = (state==R); resp_valid = (state==RESP).
- On accept:
  - latch araddr = req_addr with the low SIZE bits forced to 0;
  - latch len = req_len;
  - clear the beat counter, resp_err, and all of resp_data to 0.
- araddr, arlen, arsize and arburst are stable for the whole time arvalid is high. arvalid is never dropped before arready.
- Each R-state beat (rvalid, rready high):
  - if the counter is ≤ len, store rdata into slot[counter] and increment the counter;
  - otherwise drop the data, set resp_err, and hold the counter.
- resp_err is sticky per burst and is set by any of:
  - rresp[1]==1 (SLVERR or DECERR) on any beat;
  - rlast arriving with counter < len (early last);
  - any beat beyond len+1 (overflow).
- EXOKAY (rresp 2'b01) is treated as OKAY.
- resp_beats equals the counter; it saturates at len+1.
- resp_data, resp_err and resp_beats hold their values after RESP until the next request is accepted.

## Timing
- Reset values:
  - state IDLE;
  - req_ready=1, arvalid=0, rready=0, resp_valid=0, resp_err=0;
  - resp_beats=0, resp_data=0, araddr=0, arlen=0;
  - arsize=SIZE and arburst=01 (constants).
- Request accepted at the edge ending cycle T:
  - arvalid=1 from T+1;
  - with arready=1 at T+1, rready=1 from T+2.
- A beat with rlast in cycle B gives resp_valid=1 in B+1 only.
- req_ready returns high in B+2.
- Minimum latency for a one-beat burst, from accept cycle T to resp_valid, is 3 cycles (T+3).
- req_valid is ignored whenever req_ready=0; there is no queueing.
- rvalid in IDLE, AR or RESP is ignored (rready=0).
- Reset asserted mid-burst: all outputs go to reset values immediately. The outstanding AXI transaction is abandoned; the slave must be reset by the same rst_n.
- MAX_BEATS=1: LEN_W=1 and req_len must be 0; any second beat is an overflow.

## Test plan
- Reset, then a DATA_WIDTH=32, MAX_BEATS=8 request with addr 0x1003 and len 7:
  - expected AR: araddr=0x1000, arlen=7, arsize=2, arburst=1;
  - the slave returns beats 0xA0..0xA7, with rlast on the 8th beat;
  - expected response: resp_valid pulses 1 cycle, resp_data slot i = 0xA0+i, resp_beats=8, resp_err=0.
- Len 1 burst where rvalid stalls 3 cycles between beats and arready is delayed 4 cycles:
  - arvalid and araddr are held through the delay;
  - slots 0–1 are filled and slots 2–7 read 0;
  - resp_beats=2.
- Len 3 burst with rresp=2'b10 on beat 1: resp_err=1, all 4 beats stored, resp_beats=4.
- Len 3 burst with rlast on beat 2 (early last): completes at that beat with resp_err=1 and resp_beats=2.
- Len 0 burst whose slave sends 2 beats with rlast on the 2nd: slot 0 holds beat 0, the 2nd beat is dropped, resp_err=1, resp_beats=1.
- req_valid held high throughout a burst:
  - exactly one AR issues per accept, and a second AR issues only after resp_valid;
  - rst_n pulsed low mid-R forces arvalid=0, rready=0, req_ready=1 in the same cycle.

Source files
------------

// File: rtl/axi_burst_read_master_if.sv
// Client request/response and AXI read-channel bundle for axi_burst_read_master.
// The master modport is the block's view; slave is the client + AXI slave side.
interface axi_burst_read_master_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BEATS  = 8,
    parameter int unsigned ADDR_WIDTH = 32
);
    localparam int unsigned LEN_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);

    logic                            req_valid;
    logic                            req_ready;
    logic [ADDR_WIDTH-1:0]           req_addr;
    logic [LEN_W-1:0]                req_len;
    logic                            resp_valid;
    logic [MAX_BEATS*DATA_WIDTH-1:0] resp_data;
    logic                            resp_err;
    logic [CNT_W-1:0]                resp_beats;
    logic                            arvalid;
    logic                            arready;
    logic [ADDR_WIDTH-1:0]           araddr;
    logic [7:0]                      arlen;
    logic [2:0]                      arsize;
    logic [1:0]                      arburst;
    logic                            rvalid;
    logic                            rready;
    logic [DATA_WIDTH-1:0]           rdata;
    logic [1:0]                      rresp;
    logic                            rlast;

    modport master (
        input  req_valid, req_addr, req_len, arready, rvalid, rdata, rresp, rlast,
        output req_ready, resp_valid, resp_data, resp_err, resp_beats,
        output arvalid, araddr, arlen, arsize, arburst, rready
    );

    modport slave (
        output req_valid, req_addr, req_len, arready, rvalid, rdata, rresp, rlast,
        input  req_ready, resp_valid, resp_data, resp_err, resp_beats,
        input  arvalid, araddr, arlen, arsize, arburst, rready
    );
endinterface

// File: rtl/axi_burst_read_master.sv
// AXI4 read master: one client request becomes one INCR burst of 1..MAX_BEATS beats,
// returned as a single wide line with error flag and received-beat count.
module axi_burst_read_master #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BEATS  = 8,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input logic                     clk,
    input logic                     rst_n,
    axi_burst_read_master_if.master bus
);
    localparam int unsigned LEN_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);
    localparam int unsigned SIZE  = $clog2(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << SIZE;

    typedef enum logic [1:0] {StIdle, StAr, StR, StResp} state_e;

    state_e                  r_state;
    logic                    r_req_ready;
    logic                    r_arvalid;
    logic                    r_rready;
    logic                    r_resp_valid;
    logic                    r_err;
    logic [ADDR_WIDTH-1:0]   r_araddr;
    logic [LEN_W-1:0]        r_len;
    logic [CNT_W-1:0]        r_cnt;
    logic [DATA_WIDTH-1:0]   r_slot [MAX_BEATS];

    logic [CNT_W-1:0]                w_len_ext;
    logic                            w_in_range;
    logic                            w_beat_err;
    logic [MAX_BEATS*DATA_WIDTH-1:0] w_resp_data;

    assign w_len_ext  = CNT_W'(r_len);
    assign w_in_range = (r_cnt <= w_len_ext);
    // SLVERR/DECERR, early last, or a beat past the requested length.
    assign w_beat_err = (bus.rresp == 2'b10) || (bus.rresp == 2'b11)
                        || (bus.rlast && (r_cnt < w_len_ext)) || !w_in_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_req_ready  <= 1'b1;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_err        <= 1'b0;
            r_araddr     <= '0;
            r_len        <= '0;
            r_cnt        <= '0;
            for (int i = 0; i < MAX_BEATS; i++) r_slot[i] <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (bus.req_valid) begin
                        r_state     <= StAr;
                        r_req_ready <= 1'b0;
                        r_arvalid   <= 1'b1;
                        r_araddr    <= bus.req_addr & ADDR_MASK;
                        r_len       <= bus.req_len;
                        r_cnt       <= '0;
                        r_err       <= 1'b0;
                        for (int i = 0; i < MAX_BEATS; i++) r_slot[i] <= '0;
                    end
                end
                StAr: begin
                    if (bus.arready) begin
                        r_state   <= StR;
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                    end
                end
                StR: begin
                    if (bus.rvalid) begin
                        if (w_in_range) begin
                            for (int i = 0; i < MAX_BEATS; i++) begin
                                if (r_cnt == CNT_W'(i)) r_slot[i] <= bus.rdata;
                            end
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                        if (w_beat_err) r_err <= 1'b1;
                        if (bus.rlast) begin
                            r_state      <= StResp;
                            r_rready     <= 1'b0;
                            r_resp_valid <= 1'b1;
                        end
                    end
                end
                StResp: begin
                    r_state     <= StIdle;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state     <= StIdle;
                    r_req_ready <= 1'b1;
                    r_arvalid   <= 1'b0;
                    r_rready    <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_resp_data = '0;
        for (int i = 0; i < MAX_BEATS; i++) w_resp_data[i*DATA_WIDTH +: DATA_WIDTH] = r_slot[i];
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.arvalid    = r_arvalid;
    assign bus.rready     = r_rready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_err;
    assign bus.resp_beats = r_cnt;
    assign bus.resp_data  = w_resp_data;
    assign bus.araddr     = r_araddr;
    assign bus.arlen      = 8'(r_len);
    assign bus.arsize     = 3'(SIZE);
    assign bus.arburst    = 2'b01;
endmodule

// File: tb/tb_axi_burst_read_master.sv
// Directed bench for axi_burst_read_master (DATA_WIDTH=32, MAX_BEATS=8).
// Inputs change and outputs are sampled on the falling edge.
module tb_axi_burst_read_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   ar_hs = 0;
    int   base;

    always #5 clk = ~clk;

    axi_burst_read_master_if #(.DATA_WIDTH(32), .MAX_BEATS(8), .ADDR_WIDTH(32)) bus ();

    axi_burst_read_master #(.DATA_WIDTH(32), .MAX_BEATS(8), .ADDR_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always @(posedge clk) if (bus.arvalid && bus.arready) ar_hs <= ar_hs + 1;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle; returns in cycle T+1 (arvalid expected high).
    task automatic issue(input logic [31:0] addr, input logic [2:0] len);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_len   = len;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic grant_ar(input int delay, input logic [31:0] exp_addr);
        for (int i = 0; i < delay; i++) begin
            chk("ar_hold_valid", bus.arvalid, 1'b1);
            chk("ar_hold_addr", bus.araddr, exp_addr);
            @(negedge clk);
        end
        bus.arready = 1'b1;
        @(negedge clk);
        bus.arready = 1'b0;
    endtask

    task automatic beat(input logic [31:0] data, input logic [1:0] resp, input logic last);
        bus.rvalid = 1'b1;
        bus.rdata  = data;
        bus.rresp  = resp;
        bus.rlast  = last;
        @(negedge clk);
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        bus.rresp  = 2'b00;
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        bus.arready   = 1'b0;
        bus.rvalid    = 1'b0;
        bus.rdata     = '0;
        bus.rresp     = 2'b00;
        bus.rlast     = 1'b0;

        // Reset values
        @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 1'b1);
        chk("rst_arvalid", bus.arvalid, 1'b0);
        chk("rst_rready", bus.rready, 1'b0);
        chk("rst_resp_valid", bus.resp_valid, 1'b0);
        chk("rst_resp_err", bus.resp_err, 1'b0);
        chk("rst_resp_beats", bus.resp_beats, 4'd0);
        chk("rst_resp_data", bus.resp_data, 256'h0);
        chk("rst_araddr", bus.araddr, 32'h0);
        chk("rst_arlen", bus.arlen, 8'd0);
        chk("rst_arsize", bus.arsize, 3'd2);
        chk("rst_arburst", bus.arburst, 2'b01);
        rst_n = 1'b1;
        @(negedge clk);

        // Full 8-beat burst, unaligned address
        issue(32'h1003, 3'd7);
        chk("t1_arvalid", bus.arvalid, 1'b1);
        chk("t1_req_ready", bus.req_ready, 1'b0);
        chk("t1_araddr", bus.araddr, 32'h1000);
        chk("t1_arlen", bus.arlen, 8'd7);
        chk("t1_arsize", bus.arsize, 3'd2);
        chk("t1_arburst", bus.arburst, 2'b01);
        grant_ar(0, 32'h1000);
        chk("t1_rready", bus.rready, 1'b1);
        chk("t1_arvalid_low", bus.arvalid, 1'b0);
        for (int i = 0; i < 8; i++) beat(32'hA0 + 32'(i), 2'b00, i == 7);
        chk("t1_resp_valid", bus.resp_valid, 1'b1);
        chk("t1_resp_data", bus.resp_data,
            256'h000000a7_000000a6_000000a5_000000a4_000000a3_000000a2_000000a1_000000a0);
        chk("t1_resp_beats", bus.resp_beats, 4'd8);
        chk("t1_resp_err", bus.resp_err, 1'b0);
        chk("t1_rready_low", bus.rready, 1'b0);
        @(negedge clk);
        chk("t1_pulse_end", bus.resp_valid, 1'b0);
        chk("t1_req_ready_back", bus.req_ready, 1'b1);
        chk("t1_beats_held", bus.resp_beats, 4'd8);

        // Len 1, AR delayed 4 cycles, 3-cycle R stall
        issue(32'h2000, 3'd1);
        grant_ar(4, 32'h2000);
        beat(32'hB0, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("t2_stall_rready", bus.rready, 1'b1);
            chk("t2_stall_no_resp", bus.resp_valid, 1'b0);
            @(negedge clk);
        end
        beat(32'hB1, 2'b00, 1'b1);
        chk("t2_resp_valid", bus.resp_valid, 1'b1);
        chk("t2_resp_data", bus.resp_data, 256'h000000b1_000000b0);
        chk("t2_resp_beats", bus.resp_beats, 4'd2);
        chk("t2_resp_err", bus.resp_err, 1'b0);
        @(negedge clk);

        // Len 3 with SLVERR on beat 1
        issue(32'h3000, 3'd3);
        grant_ar(0, 32'h3000);
        beat(32'hC0, 2'b00, 1'b0);
        beat(32'hC1, 2'b10, 1'b0);
        beat(32'hC2, 2'b00, 1'b0);
        beat(32'hC3, 2'b00, 1'b1);
        chk("t3_resp_valid", bus.resp_valid, 1'b1);
        chk("t3_resp_data", bus.resp_data, 256'h000000c3_000000c2_000000c1_000000c0);
        chk("t3_resp_beats", bus.resp_beats, 4'd4);
        chk("t3_resp_err", bus.resp_err, 1'b1);
        @(negedge clk);

        // Len 3 with early rlast on the 2nd beat
        issue(32'h4000, 3'd3);
        grant_ar(0, 32'h4000);
        beat(32'hD0, 2'b00, 1'b0);
        beat(32'hD1, 2'b00, 1'b1);
        chk("t4_resp_valid", bus.resp_valid, 1'b1);
        chk("t4_resp_data", bus.resp_data, 256'h000000d1_000000d0);
        chk("t4_resp_beats", bus.resp_beats, 4'd2);
        chk("t4_resp_err", bus.resp_err, 1'b1);
        @(negedge clk);

        // Len 0 with an extra beat: overflow dropped
        issue(32'h5004, 3'd0);
        grant_ar(0, 32'h5004);
        beat(32'hE0, 2'b00, 1'b0);
        chk("t5_rready_after_beat0", bus.rready, 1'b1);
        beat(32'hE1, 2'b00, 1'b1);
        chk("t5_resp_valid", bus.resp_valid, 1'b1);
        chk("t5_resp_data", bus.resp_data, 256'h000000e0);
        chk("t5_resp_beats", bus.resp_beats, 4'd1);
        chk("t5_resp_err", bus.resp_err, 1'b1);
        @(negedge clk);

        // Len 0 with EXOKAY: no error
        issue(32'h6000, 3'd0);
        grant_ar(0, 32'h6000);
        beat(32'h12345678, 2'b01, 1'b1);
        chk("t6_resp_data", bus.resp_data, 256'h12345678);
        chk("t6_resp_err", bus.resp_err, 1'b0);
        chk("t6_resp_beats", bus.resp_beats, 4'd1);
        @(negedge clk);

        // req_valid held high: one AR per accept, then reset mid-R
        base = ar_hs;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h7000;
        bus.req_len   = 3'd0;
        bus.arready   = 1'b1;
        @(negedge clk);
        chk("t7_arvalid", bus.arvalid, 1'b1);
        @(negedge clk);
        chk("t7_rready", bus.rready, 1'b1);
        beat(32'hF0, 2'b00, 1'b1);
        chk("t7_resp_valid", bus.resp_valid, 1'b1);
        chk("t7_one_ar", ar_hs - base, 1);
        chk("t7_resp_data", bus.resp_data, 256'h000000f0);
        @(negedge clk);
        chk("t7_idle_ready", bus.req_ready, 1'b1);
        chk("t7_no_ar_in_idle", bus.arvalid, 1'b0);
        @(negedge clk);
        chk("t7_second_ar", bus.arvalid, 1'b1);
        chk("t7_still_one_ar", ar_hs - base, 1);
        @(negedge clk);
        chk("t7_two_ar", ar_hs - base, 2);
        chk("t7_rready2", bus.rready, 1'b1);
        bus.req_valid = 1'b0;
        bus.arready   = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t7_rst_arvalid", bus.arvalid, 1'b0);
        chk("t7_rst_rready", bus.rready, 1'b0);
        chk("t7_rst_req_ready", bus.req_ready, 1'b1);
        chk("t7_rst_beats", bus.resp_beats, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t7_post_rst_ready", bus.req_ready, 1'b1);
        chk("t7_post_rst_arvalid", bus.arvalid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
